storage_ro_arbiter: RTL and testbench
=====================================

# storage_ro_arbiter

Round-robin arbiter that shares the single read-only port of the management SRAM storage between two requesters: the management core (CPU read-only path) and housekeeping (SPI-driven read-back). It sits between the core/housekeeping read requests and the storage block's RO port. It issues at most one RAM read per cycle, tags each read with its owner, and returns data to that owner. A saturating contention counter is provided for debug.

## Interface
- ADDR_W, 8, RAM word address width
- DATA_W, 32, RAM data width
- CNT_W, 16, contention counter width

Ports:
- core_clk  in  1  single clock for all logic; both requesters are synchronous to it
- core_rst  in  1  synchronous, active-high reset
- core_req  in  1  core read request; held high with stable core_addr until core_gnt
- core_addr  in  ADDR_W  core read address
- core_gnt  out  1  one-cycle pulse: core request accepted and issued to RAM
- core_rvalid  out  1  one-cycle pulse: core_rdata valid
- core_rdata  out  DATA_W  read data for core
- hk_req  in  1  housekeeping read request, same rules as core_req
- hk_addr  in  ADDR_W  housekeeping read address
- hk_gnt  out  1  housekeeping grant pulse
- hk_rvalid  out  1  housekeeping data-valid pulse
- hk_rdata  out  DATA_W  read data for housekeeping
- ram_csb  out  1  RAM RO port chip select, active low
- ram_addr  out  ADDR_W  RAM RO port address
- ram_rdata  in  DATA_W  RAM RO port data, valid in the cycle after ram_csb is low
- clr_cnt  in  1  synchronous clear of contention_cnt
- contention_cnt  out  CNT_W  saturating count of cycles with a deferred eligible request

## Operation
- Eligibility in cycle t: a requester is eligible if its req is high and its gnt is not high in cycle t. The request visible alongside its own grant is the already-accepted request.
- Arbitration in cycle t on eligible requesters:
  - none: no grant; ram_csb=1 at t+1.
  - one: that requester wins.
  - both: the requester not granted most recently wins; contention_cnt increments.
- last_winner register is updated on every grant. Its reset value is hk, so core wins the first tie after reset.
- Winner registered at edge end of t. In cycle t+1: gnt_x=1, ram_csb=0, ram_addr=addr_x.
- Owner tag pipelined one stage. In cycle t+2, ram_rdata is valid; it is captured at the end of t+2. In cycle t+3: x_rvalid=1, x_rdata=captured data.
- Pipelined: a new RAM read can issue every cycle. Each requester sustains at most one accepted read per 2 cycles. Two interleaved requesters reach full port bandwidth.
- x_rdata holds its last value when x_rvalid=0. Data is never returned to the non-owner.
- ram_csb=1 on an idle cycle. ram_addr holds its last value when idle.
- contention_cnt:
  - saturates at 2^CNT_W-1;
  - clr_cnt takes priority over increment (cleared to 0 next cycle);
  - unaffected by which side wins.
- Reset mid-operation: all in-flight reads are discarded. No rvalid is emitted for reads issued before reset. last_winner returns to hk.

## Timing
- Reset values: ram_csb=1; ram_addr=0; core_gnt=hk_gnt=0; core_rvalid=hk_rvalid=0; core_rdata=hk_rdata=0; contention_cnt=0.
- Request-to-grant latency: 1 cycle when uncontended; 2 cycles when losing one tie.
- Request-to-rvalid latency: 3 cycles when uncontended.
- Maximum wait while continuously requesting: one lost tie, guaranteed by round-robin. No starvation.
- Dropping req before gnt is legal and cancels the request, provided arbitration has not already selected it in that cycle. If the grant was already registered, gnt and rvalid still occur and the requester ignores them.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset then core_req=1, addr=0x12, with RAM model returning 0xDEADBEEF. Required: core_gnt at +1, ram_csb=0 / ram_addr=0x12 at +1, core_rvalid=1 with core_rdata=0xDEADBEEF at +3, hk_rvalid stays 0.
- Both requests rise together (core 0x01, hk 0x02) and are held for 8 cycles. Required: grants alternate core, hk, core, hk…; ram_addr alternates 0x01/0x02; ram_csb=0 every cycle; each rvalid is routed to the correct owner; contention_cnt counts only the cycles with a deferred eligible request.
- hk alone requesting continuously. Required: hk_gnt every other cycle (one read per 2 cycles); contention_cnt stays 0.
- Assert core_rst one cycle after a grant. Required: no rvalid for that read, all outputs at reset values next cycle, and the first subsequent tie is won by core.
- Force contention_cnt to saturation (use CNT_W=4; 20 contended cycles). Required: holds 15. Then clr_cnt and a contended cycle together. Required: reads 0 next cycle.

Source files
------------

// File: rtl/storage_ro_arbiter_if.sv
// Request/response bundle between the two RO requesters, the storage RO port and the arbiter.
// The "master" side is the requesters plus the RAM; the "slave" side is the arbiter.
interface storage_ro_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) ();
   logic              core_req;
   logic [ADDR_W-1:0] core_addr;
   logic              core_gnt;
   logic              core_rvalid;
   logic [DATA_W-1:0] core_rdata;

   logic              hk_req;
   logic [ADDR_W-1:0] hk_addr;
   logic              hk_gnt;
   logic              hk_rvalid;
   logic [DATA_W-1:0] hk_rdata;

   logic              ram_csb;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;

   logic              clr_cnt;
   logic [CNT_W-1:0]  contention_cnt;

   modport master (
      output core_req, core_addr, hk_req, hk_addr, ram_rdata, clr_cnt,
      input  core_gnt, core_rvalid, core_rdata, hk_gnt, hk_rvalid, hk_rdata,
             ram_csb, ram_addr, contention_cnt
   );

   modport slave (
      input  core_req, core_addr, hk_req, hk_addr, ram_rdata, clr_cnt,
      output core_gnt, core_rvalid, core_rdata, hk_gnt, hk_rvalid, hk_rdata,
             ram_csb, ram_addr, contention_cnt
   );
endinterface

// File: rtl/storage_ro_arbiter.sv
// Round-robin arbiter sharing the storage RO port between the core and housekeeping.
// Issue -> RAM access -> data capture pipeline; all outputs registered.
module storage_ro_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                 core_clk,
   input  logic                 core_rst,
   storage_ro_arbiter_if.slave  bus
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic              r_core_gnt;
   logic              r_hk_gnt;
   logic              r_ram_csb;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_last_hk;
   logic              r_vld_p1;
   logic              r_own_hk_p1;
   logic              r_core_rvalid;
   logic              r_hk_rvalid;
   logic [DATA_W-1:0] r_core_rdata;
   logic [DATA_W-1:0] r_hk_rdata;
   logic [CNT_W-1:0]  r_cnt;

   logic w_core_elig;
   logic w_hk_elig;
   logic w_tie;
   logic w_grant_any;
   logic w_win_hk;

   // A request seen alongside its own grant is the one already accepted.
   always_comb begin
      w_core_elig = bus.core_req & ~r_core_gnt;
      w_hk_elig   = bus.hk_req & ~r_hk_gnt;
      w_tie       = w_core_elig & w_hk_elig;
      w_grant_any = w_core_elig | w_hk_elig;
      w_win_hk    = w_tie ? ~r_last_hk : w_hk_elig;
   end

   // ---- stage p0: arbitration result drives grant and RAM port ----
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         r_core_gnt <= 1'b0;
         r_hk_gnt   <= 1'b0;
         r_ram_csb  <= 1'b1;
         r_ram_addr <= '0;
         r_last_hk  <= 1'b1;
      end else begin
         r_core_gnt <= w_grant_any & ~w_win_hk;
         r_hk_gnt   <= w_grant_any & w_win_hk;
         r_ram_csb  <= ~w_grant_any;
         if (w_grant_any) begin
            r_ram_addr <= w_win_hk ? bus.hk_addr : bus.core_addr;
            r_last_hk  <= w_win_hk;
         end
      end
   end

   // ---- stage p1: owner tag follows the read while the RAM fetches ----
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         r_vld_p1    <= 1'b0;
         r_own_hk_p1 <= 1'b0;
      end else begin
         r_vld_p1    <= ~r_ram_csb;
         r_own_hk_p1 <= r_hk_gnt;
      end
   end

   // ---- stage p2: capture RAM data for the owning requester only ----
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         r_core_rvalid <= 1'b0;
         r_hk_rvalid   <= 1'b0;
         r_core_rdata  <= '0;
         r_hk_rdata    <= '0;
      end else begin
         r_core_rvalid <= r_vld_p1 & ~r_own_hk_p1;
         r_hk_rvalid   <= r_vld_p1 & r_own_hk_p1;
         if (r_vld_p1 & ~r_own_hk_p1) r_core_rdata <= bus.ram_rdata;
         if (r_vld_p1 & r_own_hk_p1)  r_hk_rdata   <= bus.ram_rdata;
      end
   end

   always_ff @(posedge core_clk) begin
      if (core_rst || bus.clr_cnt) r_cnt <= '0;
      else if (w_tie)              r_cnt <= sat_inc(r_cnt);
   end

   assign bus.core_gnt       = r_core_gnt;
   assign bus.hk_gnt         = r_hk_gnt;
   assign bus.ram_csb        = r_ram_csb;
   assign bus.ram_addr       = r_ram_addr;
   assign bus.core_rvalid    = r_core_rvalid;
   assign bus.hk_rvalid      = r_hk_rvalid;
   assign bus.core_rdata     = r_core_rdata;
   assign bus.hk_rdata       = r_hk_rdata;
   assign bus.contention_cnt = r_cnt;

endmodule

// File: tb/tb_storage_ro_arbiter.sv
// Directed bench for storage_ro_arbiter with a one-cycle-latency RAM model.
module tb_storage_ro_arbiter;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   storage_ro_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   storage_ro_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .core_clk (clk),
      .core_rst (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
      return (a == 8'h12) ? 32'hDEADBEEF : {24'hA5A5A5, a};
   endfunction

   always @(posedge clk) begin
      if (!bus.ram_csb) bus.ram_rdata <= mem_fn(bus.ram_addr);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.core_req  = 1'b0;
      bus.core_addr = '0;
      bus.hk_req    = 1'b0;
      bus.hk_addr   = '0;
      bus.clr_cnt   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      n_total++; if (bus.ram_csb !== 1'b1) $display("FAIL rst_csb: got %b expected 1", bus.ram_csb); else n_pass++;
      n_total++; if (bus.ram_addr !== 8'h00) $display("FAIL rst_addr: got %h expected 00", bus.ram_addr); else n_pass++;
      n_total++; if ({bus.core_gnt, bus.hk_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b expected 00", {bus.core_gnt, bus.hk_gnt}); else n_pass++;
      n_total++; if ({bus.core_rvalid, bus.hk_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b expected 00", {bus.core_rvalid, bus.hk_rvalid}); else n_pass++;
      n_total++; if (bus.core_rdata !== 32'h0 || bus.hk_rdata !== 32'h0) $display("FAIL rst_rdata: got %h/%h expected 0/0", bus.core_rdata, bus.hk_rdata); else n_pass++;
      n_total++; if (bus.contention_cnt !== 4'd0) $display("FAIL rst_cnt: got %0d expected 0", bus.contention_cnt); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single_core();
      bus.core_req  = 1'b1;
      bus.core_addr = 8'h12;
      step();
      n_total++; if (bus.core_gnt !== 1'b1) $display("FAIL single_gnt: got %b expected 1", bus.core_gnt); else n_pass++;
      n_total++; if (bus.ram_csb !== 1'b0 || bus.ram_addr !== 8'h12) $display("FAIL single_port: got csb=%b addr=%h expected csb=0 addr=12", bus.ram_csb, bus.ram_addr); else n_pass++;
      bus.core_req = 1'b0;
      step();
      n_total++; if (bus.core_gnt !== 1'b0 || bus.ram_csb !== 1'b1 || bus.core_rvalid !== 1'b0) $display("FAIL single_t2: got gnt=%b csb=%b rv=%b expected 0 1 0", bus.core_gnt, bus.ram_csb, bus.core_rvalid); else n_pass++;
      n_total++; if (bus.ram_addr !== 8'h12) $display("FAIL single_addr_hold: got %h expected 12", bus.ram_addr); else n_pass++;
      step();
      n_total++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'hDEADBEEF) $display("FAIL single_rdata: got rv=%b data=%h expected rv=1 data=deadbeef", bus.core_rvalid, bus.core_rdata); else n_pass++;
      n_total++; if (bus.hk_rvalid !== 1'b0 || bus.hk_rdata !== 32'h0) $display("FAIL single_hk_quiet: got rv=%b data=%h expected rv=0 data=0", bus.hk_rvalid, bus.hk_rdata); else n_pass++;
      step();
      n_total++; if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'hDEADBEEF) $display("FAIL single_hold: got rv=%b data=%h expected rv=0 data=deadbeef", bus.core_rvalid, bus.core_rdata); else n_pass++;
   endtask

   task automatic test_alternate();
      logic              e_cg, e_hg, e_csb, e_crv, e_hrv;
      logic [ADDR_W-1:0] e_addr;
      do_reset();
      bus.core_req  = 1'b1;
      bus.core_addr = 8'h01;
      bus.hk_req    = 1'b1;
      bus.hk_addr   = 8'h02;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 8) begin
            bus.core_req = 1'b0;
            bus.hk_req   = 1'b0;
         end
         e_cg   = (k <= 8) && (k % 2 == 1);
         e_hg   = (k <= 8) && (k % 2 == 0);
         e_csb  = (k > 8);
         e_addr = (k >= 8 || k % 2 == 0) ? 8'h02 : 8'h01;
         e_crv  = (k == 3) || (k == 5) || (k == 7) || (k == 9);
         e_hrv  = (k == 4) || (k == 6) || (k == 8) || (k == 10);
         n_total++; if (bus.core_gnt !== e_cg || bus.hk_gnt !== e_hg) $display("FAIL alt_gnt[%0d]: got %b%b expected %b%b", k, bus.core_gnt, bus.hk_gnt, e_cg, e_hg); else n_pass++;
         n_total++; if (bus.ram_csb !== e_csb || bus.ram_addr !== e_addr) $display("FAIL alt_port[%0d]: got csb=%b addr=%h expected csb=%b addr=%h", k, bus.ram_csb, bus.ram_addr, e_csb, e_addr); else n_pass++;
         n_total++; if (bus.core_rvalid !== e_crv || bus.hk_rvalid !== e_hrv) $display("FAIL alt_rvalid[%0d]: got %b%b expected %b%b", k, bus.core_rvalid, bus.hk_rvalid, e_crv, e_hrv); else n_pass++;
         if (e_crv) begin
            n_total++; if (bus.core_rdata !== 32'hA5A5A501) $display("FAIL alt_core_data[%0d]: got %h expected a5a5a501", k, bus.core_rdata); else n_pass++;
         end
         if (e_hrv) begin
            n_total++; if (bus.hk_rdata !== 32'hA5A5A502) $display("FAIL alt_hk_data[%0d]: got %h expected a5a5a502", k, bus.hk_rdata); else n_pass++;
         end
      end
      n_total++; if (bus.contention_cnt !== 4'd1) $display("FAIL alt_cnt: got %0d expected 1", bus.contention_cnt); else n_pass++;
   endtask

   task automatic test_hk_alone();
      logic e_hg, e_hrv;
      do_reset();
      bus.hk_req  = 1'b1;
      bus.hk_addr = 8'h30;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 6) bus.hk_req = 1'b0;
         e_hg  = (k <= 5) && (k % 2 == 1);
         e_hrv = (k == 3) || (k == 5) || (k == 7);
         n_total++; if (bus.hk_gnt !== e_hg || bus.core_gnt !== 1'b0 || bus.ram_csb !== !e_hg) $display("FAIL hk_gnt[%0d]: got hg=%b cg=%b csb=%b expected hg=%b cg=0", k, bus.hk_gnt, bus.core_gnt, bus.ram_csb, e_hg); else n_pass++;
         n_total++; if (bus.hk_rvalid !== e_hrv || bus.core_rvalid !== 1'b0) $display("FAIL hk_rvalid[%0d]: got hk=%b core=%b expected hk=%b core=0", k, bus.hk_rvalid, bus.core_rvalid, e_hrv); else n_pass++;
         if (e_hrv) begin
            n_total++; if (bus.hk_rdata !== 32'hA5A5A530) $display("FAIL hk_data[%0d]: got %h expected a5a5a530", k, bus.hk_rdata); else n_pass++;
         end
      end
      n_total++; if (bus.contention_cnt !== 4'd0) $display("FAIL hk_cnt: got %0d expected 0", bus.contention_cnt); else n_pass++;
   endtask

   task automatic test_midreset();
      do_reset();
      bus.core_req  = 1'b1;
      bus.core_addr = 8'h12;
      step();
      n_total++; if (bus.core_gnt !== 1'b1) $display("FAIL mr_gnt: got %b expected 1", bus.core_gnt); else n_pass++;
      rst = 1'b1;
      bus.core_req = 1'b0;
      step();
      rst = 1'b0;
      n_total++; if (bus.ram_csb !== 1'b1 || bus.ram_addr !== 8'h00 || bus.core_gnt !== 1'b0) $display("FAIL mr_port: got csb=%b addr=%h gnt=%b expected 1 00 0", bus.ram_csb, bus.ram_addr, bus.core_gnt); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_total++; if (bus.core_rvalid !== 1'b0 || bus.hk_rvalid !== 1'b0) $display("FAIL mr_rvalid[%0d]: got %b%b expected 00", k, bus.core_rvalid, bus.hk_rvalid); else n_pass++;
         step();
      end
      bus.core_req  = 1'b1;
      bus.core_addr = 8'h01;
      bus.hk_req    = 1'b1;
      bus.hk_addr   = 8'h02;
      step();
      bus.core_req = 1'b0;
      bus.hk_req   = 1'b0;
      n_total++; if (bus.core_gnt !== 1'b1 || bus.hk_gnt !== 1'b0) $display("FAIL mr_tie: got cg=%b hg=%b expected cg=1 hg=0", bus.core_gnt, bus.hk_gnt); else n_pass++;
      for (int k = 0; k < 4; k++) step();
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] e_cnt;
      do_reset();
      bus.core_addr = 8'h05;
      bus.hk_addr   = 8'h06;
      for (int i = 0; i < 20; i++) begin
         bus.core_req = 1'b1;
         bus.hk_req   = 1'b1;
         step();
         bus.core_req = 1'b0;
         bus.hk_req   = 1'b0;
         e_cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
         n_total++; if (bus.contention_cnt !== e_cnt) $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, bus.contention_cnt, e_cnt); else n_pass++;
         step();
      end
      bus.core_req = 1'b1;
      bus.hk_req   = 1'b1;
      bus.clr_cnt  = 1'b1;
      step();
      bus.core_req = 1'b0;
      bus.hk_req   = 1'b0;
      bus.clr_cnt  = 1'b0;
      n_total++; if (bus.contention_cnt !== 4'd0) $display("FAIL clr_cnt: got %0d expected 0", bus.contention_cnt); else n_pass++;
      step();
      n_total++; if (bus.contention_cnt !== 4'd0) $display("FAIL clr_hold: got %0d expected 0", bus.contention_cnt); else n_pass++;
      bus.core_req = 1'b1;
      bus.hk_req   = 1'b1;
      step();
      bus.core_req = 1'b0;
      bus.hk_req   = 1'b0;
      n_total++; if (bus.contention_cnt !== 4'd1) $display("FAIL clr_reinc: got %0d expected 1", bus.contention_cnt); else n_pass++;
      for (int k = 0; k < 4; k++) step();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      idle_inputs();
      test_reset();
      test_single_core();
      test_alternate();
      test_hk_alone();
      test_midreset();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
